pwm_led_core: RTL and testbench
===============================

Name: pwm_led_core

Overview:
- Single-channel LED PWM generator, instantiated by the TinyTapeout top-level wrapper.
- The wrapper drives duty and prescale from ui_in/uio_in; pwm_out drives one uo_out pin.
- Duty updates use a valid/ready handshake and are shadowed, so they apply only at a period boundary (glitch-free).

Parameters:
- CNT_W, 8, width of duty and period counter; period = 2^CNT_W-1 ticks.
- PRESCALE_W, 8, width of prescale divider value.
- INVERT, 0, 1 = active-low pwm_out (for common-anode LEDs).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  run PWM; low = idle, output off
- prescale_in  input  PRESCALE_W  tick every prescale_in+1 clk cycles
- duty_in  input  CNT_W  requested duty (0 = off, 2^CNT_W-1 = fully on)
- duty_valid  input  1  duty_in valid
- duty_ready  output  1  core can accept duty_in
- pwm_out  output  1  registered PWM output
- period_tick  output  1  one-cycle pulse at each period wrap
- duty_active  output  CNT_W  duty value currently applied

Behaviour:
- Reset (rst=1 at a clk edge):
  - pwm_out = INVERT; period_tick = 0; duty_active = 0; duty_ready = 1.
  - Prescaler, period counter and pending register cleared.
  - State = IDLE.
- States:
  - IDLE (enable=0).
  - RUN (enable=1).
  - IDLE->RUN when enable=1. Counters start from 0; the first tick comes prescale+1 cycles later.
  - RUN->IDLE when enable=0. Counters clear in the same cycle; pwm_out is forced inactive next cycle.
- Prescaler:
  - ps_cnt counts 0..prescale_q; tick when ps_cnt==prescale_q, then ps_cnt returns to 0.
  - prescale_q=0 gives a tick every clk.
  - prescale_q latches prescale_in in IDLE and at each period wrap only.
- Period counter:
  - cnt advances on tick through 0..2^CNT_W-2 and wraps to 0.
  - wrap = tick && cnt==2^CNT_W-2.
  - period_tick pulses on the cycle after wrap.
- Output:
  - pwm_out = (cnt < duty_active) XOR INVERT, registered, so it trails cnt by 1 cycle.
  - duty 0: never active. duty 2^CNT_W-1: always active.
- Handshake:
  - Transfer occurs when duty_valid && duty_ready.
  - IDLE: transfer writes duty_active directly; duty_ready stays 1.
  - RUN: transfer writes the pending register, sets pend_full, and duty_ready drops the next cycle (duty_ready = !pend_full).
  - At wrap with pend_full: duty_active <= pend, pend_full clears, duty_ready returns 1 the next cycle.
  - Accept on the same cycle as wrap (pend empty): value is held pending and applied at the following wrap. No bypass.
  - Back-to-back valid while ready=0: held off; the source must keep duty_valid and duty_in stable.
  - RUN->IDLE with pend_full: pend is copied to duty_active and pend_full clears.
- Reset mid-period: immediate return to reset values; no partial pulse is emitted after the reset edge.

Optional Feature:
- PWM_LED_FADE_EN defined:
  - At each wrap, duty_active steps +1 or -1 toward the target (last accepted duty), instead of jumping.
  - pend_full clears only when duty_active == target, so duty_ready stays low during the ramp.
  - A transfer in IDLE still writes duty_active directly.
- Undefined: step update at wrap as above. No fade logic is synthesised.

Decomposition:
- Package pwm_led_pkg holds:
  - state enum (IDLE, RUN);
  - default CNT_W and PRESCALE_W localparams;
  - function period_max(width) = 2^width-2.
- One sub-module, pwm_led_prescaler: ps_cnt, prescale_q latch, tick output, clear input.
- Period counter, shadow/handshake and FSM stay in pwm_led_core.

Test Plan:
- Reset, then enable=1, prescale_in=0, duty 64 accepted in IDLE -> pwm_out high for exactly 64 of every 255 cycles; period_tick every 255 cycles.
- RUN with duty 64, send duty 200 mid-period -> duty_ready low the next cycle; duty_active stays 64 until wrap, then becomes 200; duty_ready high one cycle after wrap.
- Duty 0 and duty 255 (CNT_W=8) -> pwm_out constant 0 and constant 1 across 3 periods; no glitch at the wrap.
- prescale_in=3, duty 10 -> 40 high cycles per 1020-cycle period; changing prescale_in to 1 mid-period takes effect only after the next wrap.
- Drop enable mid-period with pending 100, then assert rst mid-period on a second run -> pwm_out inactive next cycle; duty_active=100; after rst all outputs at reset values.
- PWM_LED_FADE_EN, duty_active 10, accept 13 -> duty_active 11,12,13 on three successive wraps; duty_ready low until 13 is reached.

Source files
------------

// File: rtl/pwm_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_led_pkg
// Purpose  : Shared types, default widths and helpers for the LED PWM core.
//            - pwm_state_t        : core FSM states (IDLE, RUN)
//            - c_default_cnt_w    : default duty / period counter width
//            - c_default_prescale_w : default prescale divider width
//            - period_max(width)  : last period counter value (2^width - 2)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_led_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int c_default_cnt_w      = 8;
    localparam int c_default_prescale_w = 8;

    // The period counter runs 0..2^width-2, giving 2^width-1 ticks per period
    // so that the all-ones duty value keeps the output permanently active.
    function automatic int period_max(input int width);
        return (1 << width) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_led_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_led_prescaler
// Purpose  : Clock divider producing the PWM tick strobe. Ticks once every
//            prescale_q+1 clk cycles; prescale_q is captured only on load.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clear           - hold divider at 0 and suppress tick
//            load            - capture prescale_in into prescale_q
//            prescale_in     - requested divider value
//            tick            - one-cycle strobe when divider reaches prescale_q
// Revision : 1.0 - initial release
// ============================================================================
module pwm_led_prescaler
    import pwm_led_pkg::*;
#(
    parameter int PRESCALE_W = c_default_prescale_w
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale_in,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_prescale_q;
    logic [PRESCALE_W-1:0] r_ps_cnt;

    assign tick = !clear && (r_ps_cnt == r_prescale_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale_q <= '0;
            r_ps_cnt     <= '0;
        end else begin
            if (load) begin
                r_prescale_q <= prescale_in;
            end
            if (clear || tick) begin
                r_ps_cnt <= '0;
            end else begin
                r_ps_cnt <= r_ps_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_led_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_led_core
// Purpose  : Single-channel LED PWM generator with shadowed duty updates.
//            Duty writes arriving while running are held in a pending
//            register and applied only at a period wrap (glitch-free).
// Ports    : clk, rst     - clock, synchronous active-high reset
//            enable       - run PWM (low = idle, output inactive)
//            prescale_in  - tick every prescale_in+1 clk cycles
//            duty_in      - requested duty, duty_valid / duty_ready handshake
//            pwm_out      - registered PWM output (active-low if INVERT)
//            period_tick  - one-cycle pulse the cycle after each period wrap
//            duty_active  - duty value currently applied
// Options  : PWM_LED_FADE_EN - when defined, duty_active steps by one per
//            wrap toward the last accepted duty instead of jumping.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_led_core
    import pwm_led_pkg::*;
#(
    parameter int CNT_W      = c_default_cnt_w,
    parameter int PRESCALE_W = c_default_prescale_w,
    parameter bit INVERT     = 1'b0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale_in,
    input  logic [CNT_W-1:0]      duty_in,
    input  logic                  duty_valid,
    output logic                  duty_ready,
    output logic                  pwm_out,
    output logic                  period_tick,
    output logic [CNT_W-1:0]      duty_active
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(period_max(CNT_W));

    pwm_state_t       r_state;
    pwm_state_t       w_state_next;

    logic             w_run;
    logic             w_leave;
    logic             w_tick;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_ps_load;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] r_duty_active;
    logic             r_pend_full;
    logic             r_pwm;
    logic             r_period_tick;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Counting happens only while in RUN with enable still high; the cycle
    // enable drops already clears the counters.
    assign w_run     = (r_state == RUN) && enable;
    assign w_leave   = (r_state == RUN) && !enable;
    assign w_wrap    = w_tick && (r_cnt == c_cnt_max);
    assign w_xfer    = duty_valid && !r_pend_full;
    assign w_ps_load = (r_state == IDLE) || w_wrap;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    pwm_led_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .clear       (!w_run),
        .load        (w_ps_load),
        .prescale_in (prescale_in),
        .tick        (w_tick)
    );

    // ------------------------------------------------------------------
    // Period counter and period_tick
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_period_tick <= w_wrap;
            if (!w_run || w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered PWM output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= INVERT;
        end else if (!w_run) begin
            r_pwm <= INVERT;
        end else begin
            r_pwm <= (r_cnt < r_duty_active) ^ INVERT;
        end
    end

    // ------------------------------------------------------------------
    // Duty handshake and shadow register
    // ------------------------------------------------------------------
`ifdef PWM_LED_FADE_EN
    logic [CNT_W-1:0] w_fade_step;

    always_comb begin
        w_fade_step = r_duty_active;
        if (r_duty_active < r_pend) begin
            w_fade_step = r_duty_active + CNT_W'(1);
        end else if (r_duty_active > r_pend) begin
            w_fade_step = r_duty_active - CNT_W'(1);
        end
    end
`endif

    // A transfer and a pending value never coexist: duty_ready is the
    // inverse of r_pend_full, so w_xfer implies the pending slot is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
            r_pend        <= '0;
            r_pend_full   <= 1'b0;
        end else if ((r_state == IDLE) || w_leave) begin
            if (w_xfer) begin
                r_duty_active <= duty_in;
            end else if (r_pend_full) begin
                r_duty_active <= r_pend;
                r_pend_full   <= 1'b0;
            end
        end else begin
            if (w_xfer) begin
                r_pend      <= duty_in;
                r_pend_full <= 1'b1;
            end
            // Uses the registered pend flag, so a value accepted on the
            // wrap cycle itself waits for the following wrap.
            if (w_wrap && r_pend_full) begin
`ifdef PWM_LED_FADE_EN
                r_duty_active <= w_fade_step;
                r_pend_full   <= (w_fade_step != r_pend);
`else
                r_duty_active <= r_pend;
                r_pend_full   <= 1'b0;
`endif
            end
        end
    end

    assign duty_ready  = !r_pend_full;
    assign pwm_out     = r_pwm;
    assign period_tick = r_period_tick;
    assign duty_active = r_duty_active;

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_led_core
// Purpose  : Directed self-checking bench for pwm_led_core (CNT_W=8,
//            PRESCALE_W=8, INVERT=0). Honors PWM_LED_FADE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_led_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] prescale_in;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_tick;
    logic [7:0] duty_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_led_core #(
        .CNT_W      (8),
        .PRESCALE_W (8),
        .INVERT     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prescale_in (prescale_in),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .duty_active (duty_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until period_tick is seen; returns cycles taken or -1 on timeout.
    task automatic wait_tick(input int bound, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (period_tick !== 1'b1 && cycles < bound);
        if (period_tick !== 1'b1) cycles = -1;
    endtask

    task automatic measure(input int n, output int hi, output int ticks);
        hi    = 0;
        ticks = 0;
        repeat (n) begin
            step(1);
            if (pwm_out === 1'b1)     hi++;
            if (period_tick === 1'b1) ticks++;
        end
    endtask

    // Return to IDLE and write a duty value directly.
    task automatic idle_load(input logic [7:0] d);
        enable = 1'b0;
        step(2);
        duty_in    = d;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
    endtask

    initial begin
        int c;
        int hi;
        int tk;
        int bad;

        rst         = 1'b1;
        enable      = 1'b0;
        prescale_in = 8'd0;
        duty_in     = 8'd0;
        duty_valid  = 1'b0;
        step(2);

        // Reset state
        check("rst_pwm",    pwm_out,     0);
        check("rst_ptick",  period_tick, 0);
        check("rst_duty",   duty_active, 0);
        check("rst_ready",  duty_ready,  1);

        // Duty 64, prescale 0
        rst = 1'b0;
        step(1);
        idle_load(8'd64);
        check("idle_duty",  duty_active, 64);
        check("idle_ready", duty_ready,  1);
        enable = 1'b1;
        wait_tick(600, c);
        check("sync1", period_tick, 1);
        wait_tick(300, c);
        check("period255", c, 255);
        measure(255, hi, tk);
        check("high64",   hi, 64);
        check("ticks64",  tk, 1);

`ifndef PWM_LED_FADE_EN
        // Mid-period duty change 64 -> 200, applied at the wrap
        step(100);
        duty_in    = 8'd200;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
        check("pend_ready", duty_ready,  0);
        check("pend_duty",  duty_active, 64);
        bad = 0;
        c   = 0;
        do begin
            step(1);
            c++;
            if (period_tick !== 1'b1 && (duty_active !== 8'd64 || duty_ready !== 1'b0)) bad++;
        end while (period_tick !== 1'b1 && c < 300);
        check("hold_before_wrap", bad, 0);
        check("wrap2",      period_tick, 1);
        check("wrap_duty",  duty_active, 200);
        check("wrap_ready", duty_ready,  1);
        measure(255, hi, tk);
        check("high200", hi, 200);
`else
        // Fade 10 -> 13, one step per wrap
        idle_load(8'd10);
        check("fade_start", duty_active, 10);
        enable = 1'b1;
        wait_tick(600, c);
        check("fade_sync", period_tick, 1);
        step(50);
        duty_in    = 8'd13;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
        check("fade_ready0", duty_ready, 0);
        for (int k = 11; k <= 13; k++) begin
            wait_tick(300, c);
            check("fade_tick",  period_tick, 1);
            check("fade_duty",  duty_active, k);
            check("fade_ready", duty_ready,  (k == 13) ? 1 : 0);
        end
`endif

        // Duty 0: never active across 3 periods
        idle_load(8'd0);
        enable = 1'b1;
        step(3);
        measure(775, hi, tk);
        check("duty0_high",  hi, 0);
        check("duty0_ticks", tk, 3);

        // Duty 255: always active across 3 periods
        idle_load(8'd255);
        enable = 1'b1;
        wait_tick(600, c);
        check("sync255", period_tick, 1);
        measure(765, hi, tk);
        check("duty255_high",  hi, 765);
        check("duty255_ticks", tk, 3);

        // Prescale 3, duty 10
        prescale_in = 8'd3;
        idle_load(8'd10);
        enable = 1'b1;
        wait_tick(1200, c);
        check("sync_ps3", period_tick, 1);
        wait_tick(1200, c);
        check("period1020", c, 1020);
        measure(1020, hi, tk);
        check("high40",  hi, 40);
        check("ticks40", tk, 1);

        // Prescale change mid-period applies after the next wrap
        step(100);
        prescale_in = 8'd1;
        wait_tick(1200, c);
        check("old_prescale", c, 920);
        wait_tick(1200, c);
        check("new_prescale", c, 510);

        // Drop enable with a pending duty of 100
        step(4);
        duty_in    = 8'd100;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
        check("p100_ready", duty_ready,  0);
        check("p100_duty",  duty_active, 10);
        check("p100_pwm",   pwm_out,     1);
        enable = 1'b0;
        step(1);
        check("off_pwm",   pwm_out,     0);
        check("off_duty",  duty_active, 100);
        check("off_ready", duty_ready,  1);

        // Second run, then reset mid-period with a pending value
        enable = 1'b1;
        step(20);
        check("run2_pwm", pwm_out, 1);
        duty_in    = 8'd7;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
        check("run2_ready", duty_ready, 0);
        rst = 1'b1;
        step(1);
        check("rst2_pwm",   pwm_out,     0);
        check("rst2_ptick", period_tick, 0);
        check("rst2_duty",  duty_active, 0);
        check("rst2_ready", duty_ready,  1);
        enable = 1'b0;
        step(1);
        rst = 1'b0;
        step(5);
        check("post_rst_pwm", pwm_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
